// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the program-counter sequencer.
// Pure declarations: no latency and no flow control.
package pc_sequencer_pkg;

  localparam int PC_W      = 12;
  localparam int LABEL_W   = 8;
  localparam int RAS_DEPTH = 4;

  typedef logic [PC_W-1:0]    pc_t;
  typedef logic [LABEL_W-1:0] label_t;

  typedef enum logic [1:0] {IDLE, RUN, DONE} seq_state_e;

  localparam pc_t START_PC = '0;

endpackage

// File: rtl/ret_stack.sv
// Return-address LIFO built from a write pointer and a depth counter; push when full and pop when empty are no-ops.
// Latency: top is combinational and updates one cycle after push/pop. Backpressure: none, the caller gates push/pop.
module ret_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 12
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         clear,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] top,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] ptr;
  logic [AW:0]   depth;

  assign full  = (depth == CNT_MAX);
  assign empty = (depth == '0);
  // ptr points at the next free slot, so the live top sits one below it
  assign top   = mem[ptr - PTR_ONE];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr   <= '0;
      depth <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      ptr   <= '0;
      depth <= '0;
    end else if (push && !full) begin
      mem[ptr] <= push_data;
      ptr      <= ptr + PTR_ONE;
      depth    <= depth + CNT_ONE;
    end else if (pop && !empty) begin
      ptr   <= ptr - PTR_ONE;
      depth <= depth - CNT_ONE;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: run/halt FSM, prioritised next-PC mux, return stack and sticky stack-error flag.
// Latency: PC updates one cycle after the request, lut_label is combinational. Backpressure: stall freezes PC, stack, FSM and flag.
module pc_sequencer
  import pc_sequencer_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   start,
  input  logic   stall,
  input  logic   jump,
  input  logic   taken,
  input  logic   call,
  input  logic   ret,
  input  logic   halt,
  input  label_t label,
  output label_t lut_label,
  input  pc_t    lut_target,
  output pc_t    prog_ctr,
  output logic   busy,
  output logic   done,
  output logic   ras_err
);

  localparam pc_t PC_ONE = PC_W'(1);

  seq_state_e state, state_next;
  pc_t        pc_next;
  pc_t        pc_inc;
  pc_t        ras_top;
  logic       ras_full, ras_empty;
  logic       ras_push, ras_pop, ras_clear;
  logic       err_set;

  assign lut_label = label;
  assign busy      = (state == RUN);
  assign done      = (state == DONE);
  // Wraps modulo 2^PC_W, which also makes a return address of 4096 store as 0
  assign pc_inc    = prog_ctr + PC_ONE;

  ret_stack #(
    .DEPTH(RAS_DEPTH),
    .W    (PC_W)
  ) u_ret_stack (
    .clk      (clk),
    .reset    (reset),
    .push     (ras_push),
    .pop      (ras_pop),
    .clear    (ras_clear),
    .push_data(pc_inc),
    .top      (ras_top),
    .full     (ras_full),
    .empty    (ras_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      prog_ctr <= START_PC;
      ras_err  <= 1'b0;
    end else begin
      state    <= state_next;
      prog_ctr <= pc_next;
      if (ras_clear)    ras_err <= 1'b0;
      else if (err_set) ras_err <= 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    pc_next    = prog_ctr;
    ras_push   = 1'b0;
    ras_pop    = 1'b0;
    ras_clear  = 1'b0;
    err_set    = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          state_next = RUN;
          pc_next    = START_PC;
          ras_clear  = 1'b1;
        end
      end
      RUN: begin
        if (!stall) begin
          if (halt) begin
            state_next = DONE;
          end else if (ret) begin
            if (ras_empty) begin
              pc_next = pc_inc;
              err_set = 1'b1;
            end else begin
              pc_next = ras_top;
              ras_pop = 1'b1;
            end
          end else if (call) begin
            // The jump still happens on overflow; only the return address is lost
            pc_next = lut_target;
            if (ras_full) err_set  = 1'b1;
            else          ras_push = 1'b1;
          end else if (jump && taken) begin
            pc_next = lut_target;
          end else begin
            pc_next = pc_inc;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer with hand-computed expected values.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, stall, jump, taken, call, ret, halt;
  logic [7:0]  label;
  logic [7:0]  lut_label;
  logic [11:0] lut_target;
  logic [11:0] prog_ctr;
  logic        busy, done, ras_err;

  int n_chk  = 0;
  int n_pass = 0;

  pc_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .stall     (stall),
    .jump      (jump),
    .taken     (taken),
    .call      (call),
    .ret       (ret),
    .halt      (halt),
    .label     (label),
    .lut_label (lut_label),
    .lut_target(lut_target),
    .prog_ctr  (prog_ctr),
    .busy      (busy),
    .done      (done),
    .ras_err   (ras_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic idle_inputs();
    start = 0; stall = 0; jump = 0; taken = 0; call = 0; ret = 0; halt = 0;
    label = 8'd0; lut_target = 12'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic do_jump(input logic [11:0] tgt);
    jump = 1; taken = 1; lut_target = tgt;
    tick();
  endtask

  task automatic do_call(input logic [11:0] tgt);
    call = 1; lut_target = tgt;
    tick();
  endtask

  task automatic do_ret();
    ret = 1;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    idle_inputs();
    reset = 1;
    #2;
    chk("rst_pc", prog_ctr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", ras_err, 0);
    @(posedge clk); #1;
    reset = 0;
    tick();
    chk("idle_pc_hold", prog_ctr, 0);

    // start, then plain steps; a start pulse during RUN is ignored
    start = 1; tick();
    chk("start_pc", prog_ctr, 0);
    chk("start_busy", busy, 1);
    tick();
    chk("step1", prog_ctr, 1);
    start = 1; tick();
    chk("step2_start_ignored", prog_ctr, 2);
    tick();
    chk("step3", prog_ctr, 3);
    tick(); tick();
    chk("at5", prog_ctr, 5);

    jump = 1; taken = 1; label = 8'd3; lut_target = 12'd208;
    #1;
    chk("lut_label", lut_label, 3);
    tick();
    chk("jump_taken", prog_ctr, 208);
    do_jump(12'd5);
    jump = 1; taken = 0; label = 8'd3; lut_target = 12'd208;
    tick();
    chk("jump_not_taken", prog_ctr, 6);

    // call / return pair
    do_jump(12'd10);
    label = 8'd18;
    do_call(12'd8);
    chk("call_pc", prog_ctr, 8);
    do_ret();
    chk("ret_pc", prog_ctr, 11);
    chk("ret_err", ras_err, 0);

    // overflow: pushes 12,9,23,38 then the fifth is dropped
    do_call(12'd8);
    do_call(12'd22);
    do_call(12'd37);
    do_call(12'd52);
    chk("full_no_err", ras_err, 0);
    do_call(12'd67);
    chk("ovf_pc", prog_ctr, 67);
    chk("ovf_err", ras_err, 1);
    do_ret(); chk("pop1", prog_ctr, 38);
    do_ret(); chk("pop2", prog_ctr, 23);
    do_ret(); chk("pop3", prog_ctr, 9);
    do_ret(); chk("pop4", prog_ctr, 12);
    do_ret();
    chk("udf_pc", prog_ctr, 13);
    chk("udf_err", ras_err, 1);

    // stall freezes a pending call
    stall = 1; call = 1; lut_target = 12'd500;
    tick();
    chk("stall_pc", prog_ctr, 13);

    // wraparound
    do_jump(12'd4095);
    chk("at4095", prog_ctr, 4095);
    tick();
    chk("wrap", prog_ctr, 0);
    tick();

    // halt
    halt = 1; stall = 1; tick();
    chk("halt_stall_pc", prog_ctr, 1);
    chk("halt_stall_done", done, 0);
    halt = 1; tick();
    chk("halt_pc", prog_ctr, 1);
    chk("halt_done", done, 1);
    chk("halt_busy", busy, 0);
    do_jump(12'd100);
    chk("done_ignore_pc", prog_ctr, 1);
    chk("done_hold", done, 1);
    chk("done_err_kept", ras_err, 1);
    start = 1; tick();
    chk("restart_pc", prog_ctr, 0);
    chk("restart_err", ras_err, 0);
    chk("restart_busy", busy, 1);
    chk("restart_done", done, 0);

    // build up state, then reset mid-run
    do_ret();
    chk("pre_rst_udf", ras_err, 1);
    do_call(12'd100);
    do_call(12'd208);
    chk("pre_rst_pc", prog_ctr, 208);
    reset = 1;
    #1;
    chk("arst_pc", prog_ctr, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_err", ras_err, 0);
    label = 8'd77;
    #1;
    chk("arst_lut_label", lut_label, 77);
    @(negedge clk);
    reset = 0;
    tick();
    start = 1; tick();
    chk("post_rst_start", prog_ctr, 0);
    do_ret();
    chk("post_rst_ret_pc", prog_ctr, 1);
    chk("post_rst_ret_err", ras_err, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
